// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit and the downstream decoder.
package ifu_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    localparam int OP_LSB = 0;
    localparam int F3_LSB = 12;
    localparam int F7_LSB = 25;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch: PC register, single-outstanding memory reads and a one-entry
// output buffer toward decode, with redirect handling that drains stale fetches.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_REQ   | request for pc presented, waiting for req_ready
//  S_WAIT  | request accepted, waiting for its response
//  S_HOLD  | instruction buffered, inst_valid high until decode takes it
//  S_DRAIN | a stale request is in flight; its response is discarded
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            resp_valid,
    input  logic [31:0]     resp_data,
    input  logic            resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst_pc_q;
    logic [31:0]     inst_q;
    logic            fault_q;
    logic            inst_valid_q;
    logic            drop;
    logic            run;
    logic            accept;
    logic            redir_mis;
    logic            busy;

    assign accept    = req_valid && req_ready;
    assign redir_mis = redirect_valid && is_misaligned(redirect_pc[1:0]);

    // True when a response for an already-issued request will still arrive after this cycle.
    always_comb begin
        busy = 1'b0;
        case (state)
            S_REQ:   busy = accept;
            S_WAIT:  busy = !resp_valid;
            S_HOLD:  busy = drop && !resp_valid;
            S_DRAIN: busy = !resp_valid;
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            fault_q      <= 1'b0;
            inst_valid_q <= 1'b0;
            drop         <= 1'b0;
            run          <= 1'b0;
        end else begin
            run <= 1'b1;
            if (redirect_valid) begin
                pc <= redirect_pc;
                if (redir_mis) begin
                    // Misaligned target: no fetch, hand decode a faulting nop directly.
                    state        <= S_HOLD;
                    drop         <= busy;
                    inst_valid_q <= 1'b1;
                    inst_q       <= NOP_INST;
                    inst_pc_q    <= redirect_pc;
                    fault_q      <= 1'b1;
                end else begin
                    state        <= busy ? S_DRAIN : S_REQ;
                    drop         <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
            end else begin
                case (state)
                    S_REQ: begin
                        if (accept) state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (resp_valid) begin
                            state        <= S_HOLD;
                            inst_valid_q <= 1'b1;
                            inst_q       <= resp_err ? NOP_INST : resp_data;
                            inst_pc_q    <= pc;
                            fault_q      <= resp_err;
                        end
                    end
                    S_HOLD: begin
                        if (inst_ready) begin
                            pc           <= pc + XLEN'(4);
                            inst_valid_q <= 1'b0;
                            drop         <= 1'b0;
                            state        <= busy ? S_DRAIN : S_REQ;
                        end else begin
                            drop <= busy;
                        end
                    end
                    S_DRAIN: begin
                        if (resp_valid) state <= S_REQ;
                    end
                    default: state <= S_REQ;
                endcase
            end
        end
    end

    assign req_valid  = run && (state == S_REQ);
    assign req_addr   = pc;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_fault = fault_q;
    assign op         = inst_q[OP_LSB +: 7];
    assign funct3     = inst_q[F3_LSB +: 3];
    assign funct7     = inst_q[F7_LSB +: 7];

endmodule
